fetch_queue: RTL
================

# fetch_queue

- Parametrised instruction-fetch queue between the IF stage and the ID stage, replacing the single-entry IF-to-ID pipeline register.
- Buffers up to DEPTH {instruction, pc} pairs in a circular buffer with valid/ready handshakes on both sides.
- Supports a pipeline flush, so IF can keep fetching while ID stalls and the queue can be discarded on a taken jump.

## Interface
Parameters:
- ADDR_WIDTH, 32: width of pc.
- DATA_WIDTH, 32: width of instruction.
- DEPTH, 4: number of entries; must be a power of two and at least 2.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush_c  input  1  discard all entries, including any enqueue in the same cycle.
- enq_valid_i  input  1  IF presents a valid instruction.
- enq_ready_o  output  1  queue can accept an entry this cycle.
- instruction_i  input  DATA_WIDTH  instruction from IF.
- pc_i  input  ADDR_WIDTH  pc of instruction_i.
- deq_valid_o  output  1  head entry is valid.
- deq_ready_i  input  1  ID consumes the head this cycle; low means ID stall.
- instruction_o  output  DATA_WIDTH  head instruction; NOP when empty.
- pc_o  output  ADDR_WIDTH  head pc; 0 when empty.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
State:
- wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- count, $clog2(DEPTH)+1 bits.
- Storage array of DEPTH entries. The array needs no reset.

Handshakes:
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_c. It writes entry[wr_ptr] and increments wr_ptr.
- Dequeue fires when deq_valid_o && deq_ready_i && !flush_c. It increments rd_ptr.
- enq_ready_o = (count != DEPTH). It is combinational from count only, not from deq_ready_i, so there is no pass-through when full.
- deq_valid_o = (count != 0).

Outputs:
- instruction_o and pc_o are driven from entry[rd_ptr] when count != 0.
- When count == 0 they are NOP (32'h0000_0013, zero-extended or truncated to DATA_WIDTH) and 0.

Count update:
- Enqueue only: +1.
- Dequeue only: -1.
- Both, or neither: unchanged.

Flush:
- Has priority over everything else.
- Next cycle: wr_ptr = rd_ptr = 0, count = 0.
- A concurrent enqueue is dropped. A concurrent dequeue is not counted as consumed, because ID also flushes.

No empty bypass: a value enqueued into an empty queue becomes visible the following cycle.

Boundary cases:
- Full with deq_ready_i=1: enq_ready_o stays 0 that cycle; the freed slot is accepted the next cycle.
- Empty with deq_ready_i=1: no effect; pointers are unchanged.
- Reset asserted mid-operation: all entries are lost immediately, asynchronously. Outputs take their reset values.

Reset values of outputs:
- enq_ready_o=1, deq_valid_o=0, count_o=0.
- instruction_o=NOP, pc_o=0.

## Timing
- Latency from enqueue to visible at the head: 1 cycle.
- Throughput: 1 enqueue and 1 dequeue per cycle when 0 < count < DEPTH.
- Flush to empty: 1 cycle. enq_ready_o=1 and deq_valid_o=0 in the cycle after flush_c.
- Asynchronous reset takes effect without waiting for clk. Deassertion is assumed synchronised upstream.
- Outputs are combinational from registered state only. The dequeue outputs have no combinational path from enq_* or deq_ready_i.

## Structure
- Add NOP_INSTR = 32'h0000_0013 to package defs.
- Add a packed struct fetch_entry_t {pc, instruction} to defs, parameterised by the 32-bit default widths. The module may use local packed vectors when the widths differ.
- Single module. No sub-module is warranted; the pointer/count logic and the storage array stay inline.
- In cpu, the IF2ID_buffer instance is replaced by fetch_queue:
  - enq_valid_i is driven from IF's instruction valid.
  - IF stall = !enq_ready_o.
  - flush_c is driven from the jump control.

## Test plan
- Reset, then 4 enqueues with pc 0x0, 0x4, 0x8, 0xC and deq_ready_i=0 (DEPTH=4) -> count_o=4, enq_ready_o=0, head pc_o=0x0.
- Full queue, deq_ready_i=1 with enq_valid_i=1 held -> cycle 1: dequeue of 0x0, no enqueue. Cycle 2: enqueue accepted. Order 0x4, 0x8, 0xC, new pc is preserved.
- Steady stream, enq_valid_i=1 and deq_ready_i=1 with 10 sequential pcs -> count_o stays 1, and pc_o shows 0x0..0x24 in order one cycle after each enqueue. This wraps the pointers twice.
- count_o=3 with flush_c=1 and enq_valid_i=1 in the same cycle -> next cycle count_o=0, deq_valid_o=0, instruction_o=0x00000013, and the flushed-cycle entry never appears.
- Empty queue with deq_ready_i=1 for 3 cycles -> deq_valid_o=0, count_o=0, and pointers are unchanged; a subsequent enqueue appears with the correct pc.
- rst_n pulled low asynchronously between edges at count_o=2 -> outputs immediately return to their reset values; after release the queue is empty and accepts new entries.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the IF-to-ID fetch queue.
// Holds the NOP encoding and the default-width queue entry layout.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction-fetch queue between IF and ID.
// Flush has priority and empties the queue in one cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_c,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [DATA_WIDTH-1:0]      instruction_i,
    input  logic [ADDR_WIDTH-1:0]      pc_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [DATA_WIDTH-1:0]      instruction_o,
    output logic [ADDR_WIDTH-1:0]      pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic          enq_fire;
    logic          deq_fire;

    assign enq_ready_o = (count != FULL);
    assign deq_valid_o = (count != '0);
    assign enq_fire    = enq_valid_i && enq_ready_o && !flush_c;
    assign deq_fire    = deq_valid_o && deq_ready_i && !flush_c;

    assign head          = mem[rd_ptr];
    assign instruction_o = deq_valid_o ? head[DATA_WIDTH-1:0] : NOP;
    assign pc_o          = deq_valid_o ? head[EW-1:DATA_WIDTH] : '0;
    assign count_o       = count;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= {pc_i, instruction_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
